// File: rtl/decode_queue_pkg.sv
// Shared decode definitions for decode_queue: opcodes, format/write-back/
// memory-size codes, ALU operation codes, the decoded bundle and the
// immediate generator. The RV32M codes exist regardless of DECODE_RV32M_EN;
// only decode_core decides whether they can be produced.
package decode_queue_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_FUNC1  = 7'b0010011;
  localparam logic [6:0] OP_FUNC2  = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [2:0] {
    FT_NONE = 3'd0, FT_R = 3'd1, FT_I = 3'd2, FT_S = 3'd3,
    FT_B    = 3'd4, FT_U = 3'd5, FT_J = 3'd6
  } fmt_e;

  typedef enum logic [1:0] {
    WB_NORMAL = 2'd0, WB_MEM = 2'd1, WB_PC = 2'd2, WB_NONE = 2'd3
  } wb_e;

  typedef enum logic [1:0] {
    DM_NONE = 2'd0, DM_BYTE = 2'd1, DM_HALF = 2'd2, DM_WORD = 2'd3
  } dm_e;

  typedef enum logic [4:0] {
    IADD   = 5'd0,  ISUB  = 5'd1,  ISLL    = 5'd2,  ISLT   = 5'd3,
    ISLTU  = 5'd4,  IXOR  = 5'd5,  ISRL    = 5'd6,  ISRA   = 5'd7,
    IOR    = 5'd8,  IAND  = 5'd9,  IPAS    = 5'd10, IBEQ   = 5'd11,
    IBNE   = 5'd12, IBLT  = 5'd13, IBGE    = 5'd14, IMUL   = 5'd15,
    IMULH  = 5'd16, IMULHSU = 5'd17, IMULHU = 5'd18, IDIV  = 5'd19,
    IDIVU  = 5'd20, IREM  = 5'd21, IREMU   = 5'd22
  } alu_e;

  typedef struct packed {
    alu_e        alu;
    logic [31:0] imm;
    fmt_e        fmt;
    wb_e         wb;
    dm_e         rd_size;
    dm_e         wr_size;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        load_signed;
    logic        pc_for_a;
    logic        branch;
    logic        illegal;
  } decoded_t;

  // funct3 -> ALU op shared by register-immediate and register-register forms
  function automatic alu_e base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  base_alu = IADD;
      3'b001:  base_alu = ISLL;
      3'b010:  base_alu = ISLT;
      3'b011:  base_alu = ISLTU;
      3'b100:  base_alu = IXOR;
      3'b101:  base_alu = ISRL;
      3'b110:  base_alu = IOR;
      default: base_alu = IAND;
    endcase
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] ir, input fmt_e fmt);
    case (fmt)
      FT_I:    imm_gen = {{20{ir[31]}}, ir[31:20]};
      FT_S:    imm_gen = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      FT_B:    imm_gen = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      FT_U:    imm_gen = {ir[31:12], 12'h000};
      FT_J:    imm_gen = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm_gen = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/decode_queue_core.sv
// decode_core: purely combinational RV32I instruction decode.
// Define DECODE_RV32M_EN to accept the RV32M multiply/divide group; without
// it those encodings are flagged illegal. Illegal words decode to the default
// bundle (plus illegal=1) so they can travel down the pipe as an exception.
module decode_core
  import decode_queue_pkg::*;
(
  input  logic [31:0] ir_i,
  output decoded_t    dec_o
);

  logic [2:0] f3;
  logic [6:0] f7;

  assign f3 = ir_i[14:12];
  assign f7 = ir_i[31:25];

  // opcode/funct decode, then collapse illegal words to the default bundle
  always_comb begin
    dec_o             = '0;
    dec_o.alu         = IADD;
    dec_o.fmt         = FT_NONE;
    dec_o.wb          = WB_NORMAL;
    dec_o.rd_size     = DM_NONE;
    dec_o.wr_size     = DM_NONE;

    case (ir_i[6:0])
      OP_LUI: begin
        dec_o.fmt = FT_U;
        dec_o.alu = IPAS;
      end
      OP_AUIPC: begin
        dec_o.fmt      = FT_U;
        dec_o.pc_for_a = 1'b1;
      end
      OP_JAL: begin
        dec_o.fmt      = FT_J;
        dec_o.wb       = WB_PC;
        dec_o.pc_for_a = 1'b1;
        dec_o.branch   = 1'b1;
      end
      OP_JALR: begin
        dec_o.fmt    = FT_I;
        dec_o.wb     = WB_PC;
        dec_o.branch = 1'b1;
      end
      OP_BR: begin
        dec_o.fmt    = FT_B;
        dec_o.wb     = WB_NONE;
        dec_o.branch = 1'b1;
        case (f3)
          3'b000:  dec_o.alu = IBEQ;
          3'b001:  dec_o.alu = IBNE;
          3'b100:  dec_o.alu = IBLT;
          3'b101:  dec_o.alu = IBGE;
          default: dec_o.illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        dec_o.fmt = FT_I;
        dec_o.wb  = WB_MEM;
        case (f3)
          3'b000:  begin dec_o.rd_size = DM_BYTE; dec_o.load_signed = 1'b1; end
          3'b001:  begin dec_o.rd_size = DM_HALF; dec_o.load_signed = 1'b1; end
          3'b010:  begin dec_o.rd_size = DM_WORD; dec_o.load_signed = 1'b1; end
          3'b100:  dec_o.rd_size = DM_BYTE;
          3'b101:  dec_o.rd_size = DM_HALF;
          3'b110:  dec_o.rd_size = DM_WORD;
          default: dec_o.illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        dec_o.fmt = FT_S;
        dec_o.wb  = WB_NONE;
        case (f3)
          3'b000:  dec_o.wr_size = DM_BYTE;
          3'b001:  dec_o.wr_size = DM_HALF;
          3'b010:  dec_o.wr_size = DM_WORD;
          default: dec_o.illegal = 1'b1;
        endcase
      end
      OP_FUNC1: begin
        dec_o.fmt = FT_I;
        dec_o.alu = base_alu(f3);
        // shift-immediates carry funct7 in the upper immediate bits
        if (f3 == 3'b001 && f7 != F7_BASE) dec_o.illegal = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == F7_ALT)       dec_o.alu = ISRA;
          else if (f7 != F7_BASE) dec_o.illegal = 1'b1;
        end
      end
      OP_FUNC2: begin
        dec_o.fmt = FT_R;
        if (f7 == F7_BASE) begin
          dec_o.alu = base_alu(f3);
        end else if (f7 == F7_ALT) begin
          if (f3 == 3'b000)      dec_o.alu = ISUB;
          else if (f3 == 3'b101) dec_o.alu = ISRA;
          else                   dec_o.illegal = 1'b1;
        end else if (f7 == F7_MUL) begin
`ifdef DECODE_RV32M_EN
          case (f3)
            3'b000:  dec_o.alu = IMUL;
            3'b001:  dec_o.alu = IMULH;
            3'b010:  dec_o.alu = IMULHSU;
            3'b011:  dec_o.alu = IMULHU;
            3'b100:  dec_o.alu = IDIV;
            3'b101:  dec_o.alu = IDIVU;
            3'b110:  dec_o.alu = IREM;
            default: dec_o.alu = IREMU;
          endcase
`else
          dec_o.illegal = 1'b1;
`endif
        end else begin
          dec_o.illegal = 1'b1;
        end
      end
      OP_FENCE, OP_SYSTEM: begin
      end
      default: dec_o.illegal = 1'b1;
    endcase

    if (dec_o.illegal) begin
      dec_o.alu         = IADD;
      dec_o.fmt         = FT_NONE;
      dec_o.wb          = WB_NORMAL;
      dec_o.rd_size     = DM_NONE;
      dec_o.wr_size     = DM_NONE;
      dec_o.load_signed = 1'b0;
      dec_o.pc_for_a    = 1'b0;
      dec_o.branch      = 1'b0;
    end

    // only formats that write a register expose rd
    dec_o.rd  = (dec_o.fmt inside {FT_R, FT_I, FT_U, FT_J}) ? ir_i[11:7] : 5'd0;
    dec_o.rs1 = ir_i[19:15];
    dec_o.rs2 = ir_i[24:20];
    dec_o.imm = imm_gen(ir_i, dec_o.fmt);
  end

endmodule

// File: rtl/decode_queue.sv
// decode_queue: FIFO of decoded RV32I instructions between fetch and execute.
// Instructions are decoded by decode_core on entry; the queue only stores
// bundles and PCs and manages pointers, occupancy, handshakes and flush.
// Optional RV32M decode is enabled by defining DECODE_RV32M_EN.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_ir,
  input  logic [PC_WIDTH-1:0]        in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [4:0]                 alu_instruction,
  output logic [31:0]                immediate_value,
  output logic [2:0]                 instruction_format_type,
  output logic [1:0]                 write_back_type,
  output logic [1:0]                 read_status,
  output logic [1:0]                 write_status,
  output logic [4:0]                 rd,
  output logic [4:0]                 rs1,
  output logic [4:0]                 rs2,
  output logic                       load_signed,
  output logic                       pc_for_input_a,
  output logic                       change_branch_instruction,
  output logic                       illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  decoded_t              dec_in;
  decoded_t              mem_q [DEPTH];
  logic [PC_WIDTH-1:0]   pc_q  [DEPTH];
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q,  count_d;
  logic                  push, pop;
  decoded_t              head;

  decode_core u_decode (
    .ir_i  (in_ir),
    .dec_o (dec_in)
  );

  // ready depends on registered occupancy only, so a full queue refuses a
  // push even in a cycle where the head is being consumed
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // payload storage; contents are only observed while the entry is valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dec_in;
      pc_q[wr_ptr_q]  <= in_pc;
    end
  end

  // next pointer/occupancy; flush wins over any push or pop
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // head entry is zeroed while empty so reset clears outputs asynchronously
  assign head   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_pc = out_valid ? pc_q[rd_ptr_q]  : '0;

  assign alu_instruction           = head.alu;
  assign immediate_value           = head.imm;
  assign instruction_format_type   = head.fmt;
  assign write_back_type           = head.wb;
  assign read_status               = head.rd_size;
  assign write_status              = head.wr_size;
  assign rd                        = head.rd;
  assign rs1                       = head.rs1;
  assign rs2                       = head.rs2;
  assign load_signed               = head.load_signed;
  assign pc_for_input_a            = head.pc_for_a;
  assign change_branch_instruction = head.branch;
  assign illegal                   = head.illegal;
  assign count                     = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: hand-decoded expected bundles are queued on each
// accepted push and compared against the head outputs on each pop.
module tb_decode_queue;
  import decode_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_ir, in_pc, out_pc, immediate_value;
  logic [4:0]  alu_instruction, rd, rs1, rs2;
  logic [2:0]  instruction_format_type, count;
  logic [1:0]  write_back_type, read_status, write_status;
  logic        load_signed, pc_for_input_a, change_branch_instruction, illegal;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(4), .PC_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .alu_instruction(alu_instruction), .immediate_value(immediate_value),
    .instruction_format_type(instruction_format_type),
    .write_back_type(write_back_type), .read_status(read_status),
    .write_status(write_status), .rd(rd), .rs1(rs1), .rs2(rs2),
    .load_signed(load_signed), .pc_for_input_a(pc_for_input_a),
    .change_branch_instruction(change_branch_instruction),
    .illegal(illegal), .count(count)
  );

  typedef struct {
    logic [31:0] ir;
    logic [4:0]  alu;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [1:0]  wb, rds, wrs;
    logic [4:0]  rd, rs1, rs2;
    logic        ls, pca, br, ill;
    logic [31:0] pc;
  } exp_t;

  exp_t rows[$];
  exp_t sb[$];
  exp_t cur;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;
  logic pushed;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_row(input logic [31:0] ir, input logic [4:0] alu, input logic [31:0] imm,
                         input logic [2:0] fmt, input logic [1:0] wb, input logic [1:0] rds,
                         input logic [1:0] wrs, input logic [4:0] r_d, input logic [4:0] r_s1,
                         input logic [4:0] r_s2, input logic ls, input logic pca,
                         input logic br, input logic ill);
    exp_t e;
    e.ir = ir; e.alu = alu; e.imm = imm; e.fmt = fmt; e.wb = wb; e.rds = rds; e.wrs = wrs;
    e.rd = r_d; e.rs1 = r_s1; e.rs2 = r_s2; e.ls = ls; e.pca = pca; e.br = br; e.ill = ill;
    e.pc = '0;
    rows.push_back(e);
  endtask

  task automatic cmp_head(input exp_t e);
    chk($sformatf("pc@%h", e.ir),   out_pc, e.pc);
    chk($sformatf("alu@%h", e.ir),  alu_instruction, e.alu);
    chk($sformatf("imm@%h", e.ir),  immediate_value, e.imm);
    chk($sformatf("fmt@%h", e.ir),  instruction_format_type, e.fmt);
    chk($sformatf("wb@%h", e.ir),   write_back_type, e.wb);
    chk($sformatf("rds@%h", e.ir),  read_status, e.rds);
    chk($sformatf("wrs@%h", e.ir),  write_status, e.wrs);
    chk($sformatf("rd@%h", e.ir),   rd, e.rd);
    chk($sformatf("rs1@%h", e.ir),  rs1, e.rs1);
    chk($sformatf("rs2@%h", e.ir),  rs2, e.rs2);
    chk($sformatf("ls@%h", e.ir),   load_signed, e.ls);
    chk($sformatf("pca@%h", e.ir),  pc_for_input_a, e.pca);
    chk($sformatf("br@%h", e.ir),   change_branch_instruction, e.br);
    chk($sformatf("ill@%h", e.ir),  illegal, e.ill);
  endtask

  task automatic drive(input int k);
    cur    = rows[k];
    cur.pc = pc_ctr;
    in_ir  = cur.ir;
    in_pc  = pc_ctr;
  endtask

  // called 1 time unit after a rising edge; evaluates handshakes mid-cycle
  task automatic step();
    exp_t e;
    pushed = 1'b0;
    #4;
    if (flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          cmp_head(e);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(cur);
        pc_ctr = pc_ctr + 32'd4;
        pushed = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx, cyc;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ir = '0; in_pc = '0;

    //       ir            alu   imm           fmt      wb         rds      wrs      rd  rs1 rs2 ls pca br ill
    add_row(32'h00500093, IADD, 32'h00000005, FT_I,    WB_NORMAL, DM_NONE, DM_NONE, 1,  0,  5,  0, 0, 0, 0); // 0 addi
    add_row(32'h12345137, IPAS, 32'h12345000, FT_U,    WB_NORMAL, DM_NONE, DM_NONE, 2,  8,  3,  0, 0, 0, 0); // 1 lui
    add_row(32'hFE20AE23, IADD, 32'hFFFFFFFC, FT_S,    WB_NONE,   DM_NONE, DM_WORD, 0,  1,  2,  0, 0, 0, 0); // 2 sw
    add_row(32'h00208463, IBEQ, 32'h00000008, FT_B,    WB_NONE,   DM_NONE, DM_NONE, 0,  1,  2,  0, 0, 1, 0); // 3 beq
    add_row(32'h0020E463, IADD, 32'h00000000, FT_NONE, WB_NORMAL, DM_NONE, DM_NONE, 0,  1,  2,  0, 0, 0, 1); // 4 br f3=110
    add_row(32'hFF812283, IADD, 32'hFFFFFFF8, FT_I,    WB_MEM,    DM_WORD, DM_NONE, 5,  2, 24,  1, 0, 0, 0); // 5 lw
    add_row(32'hFF815283, IADD, 32'hFFFFFFF8, FT_I,    WB_MEM,    DM_HALF, DM_NONE, 5,  2, 24,  0, 0, 0, 0); // 6 lhu
    add_row(32'hFF813283, IADD, 32'h00000000, FT_NONE, WB_NORMAL, DM_NONE, DM_NONE, 0,  2, 24,  0, 0, 0, 1); // 7 load f3=011
    add_row(32'h010000EF, IADD, 32'h00000010, FT_J,    WB_PC,     DM_NONE, DM_NONE, 1,  0, 16,  0, 1, 1, 0); // 8 jal
    add_row(32'h402081B3, ISUB, 32'h00000000, FT_R,    WB_NORMAL, DM_NONE, DM_NONE, 3,  1,  2,  0, 0, 0, 0); // 9 sub
    add_row(32'hFFFFFFFF, IADD, 32'h00000000, FT_NONE, WB_NORMAL, DM_NONE, DM_NONE, 0, 31, 31,  0, 0, 0, 1); // 10 bad opcode
    add_row(32'h0FF0000F, IADD, 32'h00000000, FT_NONE, WB_NORMAL, DM_NONE, DM_NONE, 0,  0, 31,  0, 0, 0, 0); // 11 fence
`ifdef DECODE_RV32M_EN
    add_row(32'h022081B3, IMUL, 32'h00000000, FT_R,    WB_NORMAL, DM_NONE, DM_NONE, 3,  1,  2,  0, 0, 0, 0); // 12 mul
`else
    add_row(32'h022081B3, IADD, 32'h00000000, FT_NONE, WB_NORMAL, DM_NONE, DM_NONE, 0,  1,  2,  0, 0, 0, 1); // 12 mul
`endif
    add_row(32'hFE20BE23, IADD, 32'h00000000, FT_NONE, WB_NORMAL, DM_NONE, DM_NONE, 0,  1,  2,  0, 0, 0, 1); // 13 store f3=011
    add_row(32'h4030D093, ISRA, 32'h00000403, FT_I,    WB_NORMAL, DM_NONE, DM_NONE, 1,  1,  3,  0, 0, 0, 0); // 14 srai

    #1;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu", alu_instruction, 0);
    chk("rst_imm", immediate_value, 0);
    chk("rst_pc", out_pc, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single push on empty queue: visible the following cycle
    drive(0); in_valid = 1'b1;
    chk("t1_empty_valid", out_valid, 0);
    step();
    in_valid = 1'b0;
    chk("t1_latency_valid", out_valid, 1);
    chk("t1_fmt", instruction_format_type, FT_I);
    chk("t1_imm", immediate_value, 5);
    chk("t1_rd", rd, 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // lui then sw held, then popped one at a time
    drive(1); in_valid = 1'b1; step();
    drive(2); step();
    in_valid = 1'b0;
    chk("t2_head_alu", alu_instruction, IPAS);
    chk("t2_head_imm", immediate_value, 32'h12345000);
    step();
    chk("t2_hold_imm", immediate_value, 32'h12345000);
    out_ready = 1'b1; step();
    chk("t2_sw_imm", immediate_value, 32'hFFFFFFFC);
    chk("t2_sw_wrs", write_status, DM_WORD);
    chk("t2_sw_rd", rd, 0);
    step(); out_ready = 1'b0;

    // randomised stream over every table row
    idx = 0; cyc = 0;
    while ((idx < rows.size() || count != 0) && cyc < 2000) begin
      if (idx < rows.size()) begin
        drive(idx);
        in_valid = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      step();
      if (pushed) idx++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stream_pushed", idx, rows.size());
    chk("stream_drained", count, 0);

    // fill to full, then push+pop together at full
    for (int k = 0; k < 4; k++) begin
      drive(k + 3); in_valid = 1'b1; step();
    end
    chk("t3_full_count", count, 4);
    chk("t3_full_ready", in_ready, 0);
    drive(7); out_ready = 1'b1; step();
    in_valid = 1'b0;
    chk("t3_refused_count", count, 3);
    chk("t3_ready_again", in_ready, 1);
    for (int k = 0; k < 3; k++) step();
    out_ready = 1'b0;
    chk("t3_drained", count, 0);

    // flush with 3 queued entries and a push in the same cycle
    for (int k = 0; k < 3; k++) begin
      drive(k + 5); in_valid = 1'b1; step();
    end
    chk("t4_pre_count", count, 3);
    drive(8); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_count", count, 0);
    chk("t4_out_valid", out_valid, 0);
    step();
    chk("t4_dropped", count, 0);

    // mul alone
    drive(12); in_valid = 1'b1; step(); in_valid = 1'b0;
`ifdef DECODE_RV32M_EN
    chk("t5_alu", alu_instruction, IMUL);
    chk("t5_ill", illegal, 0);
`else
    chk("t5_alu", alu_instruction, IADD);
    chk("t5_ill", illegal, 1);
`endif
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // asynchronous reset with two entries queued
    drive(9); in_valid = 1'b1; step();
    drive(14); step(); in_valid = 1'b0;
    chk("t6_pre_count", count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_count", count, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_alu", alu_instruction, 0);
    chk("t6_rd", rd, 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // recovery after reset
    drive(0); in_valid = 1'b1; step(); in_valid = 1'b0;
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("end_sb_empty", sb.size(), 0);
    chk("end_count", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
